// File: rtl/soc_bus_xbar_if.sv
// Data-bus bundle between the core port, the interconnect and its slaves.
// Master-side fields are m_*, per-slave fields are s_* (packed by slave index).
interface soc_bus_xbar_if #(
    parameter int NUM_SLV = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic                  m_req;
    logic                  m_we;
    logic [AW-1:0]         m_addr;
    logic [DW/8-1:0]       m_sel;
    logic [DW-1:0]         m_wdata;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DW-1:0]         m_rdata;
    logic                  m_err;

    logic [NUM_SLV-1:0]    s_req;
    logic                  s_we;
    logic [AW-1:0]         s_addr;
    logic [DW/8-1:0]       s_sel;
    logic [DW-1:0]         s_wdata;
    logic [NUM_SLV-1:0]    s_gnt;
    logic [NUM_SLV-1:0]    s_rvalid;
    logic [NUM_SLV*DW-1:0] s_rdata;

    modport master (
        output m_req, m_we, m_addr, m_sel, m_wdata,
        input  m_gnt, m_rvalid, m_rdata, m_err
    );

    modport slave (
        input  s_req, s_we, s_addr, s_sel, s_wdata,
        output s_gnt, s_rvalid, s_rdata
    );

    modport xbar (
        input  m_req, m_we, m_addr, m_sel, m_wdata,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output s_req, s_we, s_addr, s_sel, s_wdata,
        input  s_gnt, s_rvalid, s_rdata
    );
endinterface

// File: rtl/soc_bus_xbar.sv
// Single-master, multi-slave data-bus interconnect with one outstanding
// transaction, registered response and error on unmapped/timeout.
module soc_bus_xbar #(
    parameter int                    NUM_SLV     = 2,
    parameter int                    AW          = 32,
    parameter int                    DW          = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE    = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK    = {32'hF000_0000, 32'hF000_0000},
    parameter int                    TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    soc_bus_xbar_if.xbar   bus
);
    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      cnt;
    logic               rvalid_q;
    logic               err_q;
    logic [DW-1:0]      rdata_q;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic [NUM_SLV-1:0] req;
    logic               gnt;
    logic               sel_rvalid;
    logic [DW-1:0]      sel_rdata;

    assign bus.s_we     = bus.m_we;
    assign bus.s_addr   = bus.m_addr;
    assign bus.s_sel    = bus.m_sel;
    assign bus.s_wdata  = bus.m_wdata;
    assign bus.s_req    = req;
    assign bus.m_gnt    = gnt;
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_err    = err_q;
    assign bus.m_rdata  = rdata_q;

    // Lowest matching slave index wins on overlapping windows.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        req = '0;
        gnt = 1'b0;
        if (rst_n && state == IDLE && bus.m_req) begin
            if (hit) begin
                req[hit_idx] = 1'b1;
                gnt          = bus.s_gnt[hit_idx];
            end else begin
                gnt = 1'b1;
            end
        end
    end

    assign sel_rvalid = bus.s_rvalid[idx_q];
    assign sel_rdata  = bus.s_rdata[int'(idx_q)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            cnt      <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt) begin
                        if (hit) begin
                            idx_q <= hit_idx;
                            cnt   <= '0;
                            state <= WAIT;
                        end else begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                            state    <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (sel_rvalid) begin
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b0;
                        rdata_q  <= sel_rdata;
                        state    <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_bus_xbar.sv
// Directed bench for soc_bus_xbar: decode, handshake, response,
// unmapped/timeout errors, overlapping windows and async reset.
module tb_soc_bus_xbar;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    soc_bus_xbar_if #(.NUM_SLV(2), .AW(32), .DW(32)) b0 ();
    soc_bus_xbar_if #(.NUM_SLV(2), .AW(32), .DW(32)) b1 ();

    soc_bus_xbar #(
        .NUM_SLV(2), .AW(32), .DW(32),
        .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYC(16)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    soc_bus_xbar #(
        .NUM_SLV(2), .AW(32), .DW(32),
        .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({32'h0000_0000, 32'h0000_0000}),
        .TIMEOUT_CYC(16)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata);
        b0.m_req   = 1'b1;
        b0.m_we    = we;
        b0.m_addr  = addr;
        b0.m_sel   = sel;
        b0.m_wdata = wdata;
    endtask

    initial begin
        rst_n       = 1'b0;
        b0.m_req    = 1'b0;
        b0.m_we     = 1'b0;
        b0.m_addr   = '0;
        b0.m_sel    = '0;
        b0.m_wdata  = '0;
        b0.s_gnt    = '0;
        b0.s_rvalid = '0;
        b0.s_rdata  = '0;
        b1.m_req    = 1'b0;
        b1.m_we     = 1'b0;
        b1.m_addr   = '0;
        b1.m_sel    = '0;
        b1.m_wdata  = '0;
        b1.s_gnt    = '0;
        b1.s_rvalid = '0;
        b1.s_rdata  = '0;

        // reset state
        cyc();
        cyc();
        #1;
        chk("rst_gnt", b0.m_gnt, 0);
        chk("rst_rvalid", b0.m_rvalid, 0);
        chk("rst_rdata", b0.m_rdata, 0);
        chk("rst_err", b0.m_err, 0);
        chk("rst_sreq", b0.s_req, 0);
        rst_n = 1'b1;

        // read from slave 0, same-cycle grant, rvalid two cycles later
        cyc();
        req0(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        b0.s_gnt = 2'b01;
        #2;
        chk("rd_sreq", b0.s_req, 2'b01);
        chk("rd_gnt", b0.m_gnt, 1);
        chk("rd_saddr", b0.s_addr, 32'h0000_0010);
        cyc();
        b0.m_req = 1'b0;
        b0.s_gnt = '0;
        #2;
        chk("rd_wait_sreq", b0.s_req, 0);
        chk("rd_wait_gnt", b0.m_gnt, 0);
        chk("rd_wait_rv", b0.m_rvalid, 0);
        cyc();
        cyc();
        b0.s_rvalid = 2'b01;
        b0.s_rdata  = {32'h5555_AAAA, 32'hDEAD_BEEF};
        #2;
        chk("rd_pre_rv", b0.m_rvalid, 0);
        cyc();
        b0.s_rvalid = '0;
        #2;
        chk("rd_rv", b0.m_rvalid, 1);
        chk("rd_rdata", b0.m_rdata, 32'hDEAD_BEEF);
        chk("rd_err", b0.m_err, 0);
        cyc();
        #2;
        chk("rd_done_rv", b0.m_rvalid, 0);
        chk("rd_done_rdata", b0.m_rdata, 0);

        // write to slave 1, grant delayed 3 cycles
        req0(1'b1, 32'h1000_0004, 4'b0011, 32'hA5A5_0F0F);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            b0.s_gnt = (k == 3) ? 2'b10 : 2'b00;
            #2;
            chk("wr_sreq", b0.s_req, 2'b10);
            chk("wr_gnt", b0.m_gnt, (k == 3) ? 1 : 0);
        end
        chk("wr_ssel", b0.s_sel, 4'b0011);
        chk("wr_swe", b0.s_we, 1);
        chk("wr_swdata", b0.s_wdata, 32'hA5A5_0F0F);
        cyc();
        b0.m_req    = 1'b0;
        b0.s_gnt    = '0;
        b0.s_rvalid = 2'b01;
        b0.s_rdata  = {32'h0000_0000, 32'h1111_2222};
        cyc();
        b0.s_rvalid = 2'b10;
        #2;
        chk("wr_ign_other", b0.m_rvalid, 0);
        cyc();
        b0.s_rvalid = '0;
        #2;
        chk("wr_rv", b0.m_rvalid, 1);
        chk("wr_err", b0.m_err, 0);
        chk("wr_rdata", b0.m_rdata, 0);
        cyc();

        // unmapped address
        req0(1'b0, 32'h2000_0000, 4'hF, 32'h0);
        b0.s_gnt = 2'b11;
        #2;
        chk("um_gnt", b0.m_gnt, 1);
        chk("um_sreq", b0.s_req, 0);
        cyc();
        b0.m_req = 1'b0;
        b0.s_gnt = '0;
        #2;
        chk("um_rv", b0.m_rvalid, 1);
        chk("um_err", b0.m_err, 1);
        chk("um_rdata", b0.m_rdata, 0);
        chk("um_resp_gnt", b0.m_gnt, 0);
        cyc();
        #2;
        chk("um_done_rv", b0.m_rvalid, 0);
        chk("um_done_err", b0.m_err, 0);

        // timeout: granted, never answered
        cyc();
        req0(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        b0.s_gnt = 2'b01;
        #2;
        chk("to_gnt", b0.m_gnt, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            b0.m_req = 1'b0;
            b0.s_gnt = '0;
            #2;
            chk("to_wait_rv", b0.m_rvalid, 0);
        end
        cyc();
        #2;
        chk("to_rv", b0.m_rvalid, 1);
        chk("to_err", b0.m_err, 1);
        chk("to_rdata", b0.m_rdata, 0);
        cyc();
        b0.s_rvalid = 2'b01;
        b0.s_rdata  = {32'h0, 32'h7777_7777};
        #2;
        chk("to_late_rv0", b0.m_rvalid, 0);
        cyc();
        b0.s_rvalid = '0;
        #2;
        chk("to_late_rv1", b0.m_rvalid, 0);

        // overlapping windows
        b1.m_req  = 1'b1;
        b1.m_addr = 32'h1234_5678;
        #2;
        chk("ov_sreq", b1.s_req, 2'b01);
        chk("ov_gnt", b1.m_gnt, 0);
        b1.m_req = 1'b0;

        // async reset during RESP
        cyc();
        req0(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        b0.s_gnt = 2'b01;
        #2;
        chk("rr_gnt", b0.m_gnt, 1);
        cyc();
        b0.m_req    = 1'b0;
        b0.s_gnt    = '0;
        b0.s_rvalid = 2'b01;
        b0.s_rdata  = {32'h0, 32'h1234_5678};
        cyc();
        b0.s_rvalid = '0;
        chk("rr_rv", b0.m_rvalid, 1);
        chk("rr_rdata", b0.m_rdata, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("rr_async_rv", b0.m_rvalid, 0);
        chk("rr_async_rdata", b0.m_rdata, 0);
        cyc();
        rst_n = 1'b1;

        // async reset during WAIT, then a clean read
        cyc();
        req0(1'b0, 32'h0000_0030, 4'hF, 32'h0);
        b0.s_gnt = 2'b01;
        #2;
        chk("rw_gnt", b0.m_gnt, 1);
        cyc();
        b0.s_gnt = '0;
        rst_n    = 1'b0;
        #1;
        chk("rw_sreq", b0.s_req, 0);
        chk("rw_mgnt", b0.m_gnt, 0);
        chk("rw_rv", b0.m_rvalid, 0);
        b0.s_rvalid = 2'b01;
        cyc();
        b0.s_rvalid = '0;
        cyc();
        rst_n = 1'b1;
        #2;
        chk("rw_post_sreq", b0.s_req, 2'b01);
        chk("rw_post_rv", b0.m_rvalid, 0);
        cyc();
        b0.s_gnt = 2'b01;
        #2;
        chk("rw_new_gnt", b0.m_gnt, 1);
        cyc();
        b0.m_req    = 1'b0;
        b0.s_gnt    = '0;
        b0.s_rvalid = 2'b01;
        b0.s_rdata  = {32'h0, 32'hCAFE_F00D};
        cyc();
        b0.s_rvalid = '0;
        #2;
        chk("rw_new_rv", b0.m_rvalid, 1);
        chk("rw_new_rdata", b0.m_rdata, 32'hCAFE_F00D);
        chk("rw_new_err", b0.m_err, 0);
        cyc();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/soc_bus_xbar.md
Name: soc_bus_xbar

Overview:
- Parametrised single-master, multi-slave data-bus interconnect.
- Sits between the core's data-memory port and NUM_SLV slaves (RAM, peripherals, ...).
- Decodes each request to one slave window and handles the request/grant handshake with one outstanding transaction.
- Registers the response and returns an error response for unmapped addresses or slaves that stop responding (timeout).

Parameters:
- NUM_SLV, 2, number of slave ports (1..8).
- AW, 32, address width.
- DW, 32, data width; byte-select width is DW/8.
- SLV_BASE, {32'h1000_0000, 32'h0000_0000}, packed NUM_SLV*AW base addresses, slave i at bits [i*AW +: AW].
- SLV_MASK, {32'hF000_0000, 32'hF000_0000}, packed NUM_SLV*AW match masks; slave i hits when (m_addr & MASK_i) == BASE_i.
- TIMEOUT_CYC, 16, maximum cycles in WAIT before an error response (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  1  master request valid; held with its fields until m_gnt.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  AW  byte address.
- m_sel  in  DW/8  byte enables.
- m_wdata  in  DW  write data.
- m_gnt  out  1  request accepted this cycle.
- m_rvalid  out  1  one-cycle response strobe.
- m_rdata  out  DW  read data, valid with m_rvalid.
- m_err  out  1  error flag, valid with m_rvalid.
- s_req  out  NUM_SLV  one-hot per-slave request.
- s_we  out  1  broadcast write enable.
- s_addr  out  AW  broadcast address.
- s_sel  out  DW/8  broadcast byte enables.
- s_wdata  out  DW  broadcast write data.
- s_gnt  in  NUM_SLV  per-slave grant.
- s_rvalid  in  NUM_SLV  per-slave response strobe, sent for both reads and writes.
- s_rdata  in  NUM_SLV*DW  per-slave read data, packed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; m_gnt=0, m_rvalid=0, m_rdata=0, m_err=0, s_req=0.
  - Timeout counter and latched slave index cleared.
  - Takes effect immediately, including mid-transaction; any in-flight response is dropped.
- Broadcast fields: s_we/s_addr/s_sel/s_wdata = master fields, combinationally, at all times.
- Decode: hit vector is computed combinationally from m_addr. With multiple hits, the lowest index wins.
- States: IDLE, WAIT, RESP.
- IDLE:
  - No m_req: all s_req=0, m_gnt=0.
  - m_req with hit on slave i: s_req[i]=1 combinationally. When s_gnt[i]=1 in the same cycle, m_gnt=1, latch i, clear the counter, go to WAIT. Otherwise stay in IDLE with s_req[i] held. No request-phase timeout.
  - m_req with no hit: m_gnt=1 the same cycle, no s_req, go to RESP with err_pending=1, rdata_pending=0.
- WAIT:
  - s_req=0, m_gnt=0.
  - s_rvalid[idx]=1: capture s_rdata[idx], err_pending=0, go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT_CYC-1 without rvalid: err_pending=1, rdata_pending=0, go to RESP.
  - s_rvalid from non-selected slaves is ignored.
- RESP:
  - m_rvalid=1 for exactly one cycle (registered output); m_rdata and m_err come from the pending registers.
  - Next state is IDLE. m_gnt=0 in RESP, so the minimum spacing between grants is 3 cycles for mapped addresses and 2 for unmapped.
  - On the return to IDLE, m_rvalid, m_err and m_rdata go back to 0.
- A late s_rvalid arriving after a timeout, or while in IDLE/RESP, is ignored.
- Writes return m_rdata=0 unless the slave drives data; m_rdata is the slave data unmodified.

Test Plan:
- Read from slave 0: m_addr=0x0000_0010, s_gnt[0]=1 same cycle, s_rvalid[0] 2 cycles later with s_rdata=0xDEAD_BEEF -> m_gnt=1 in cycle 0, m_rvalid=1, m_rdata=0xDEAD_BEEF, m_err=0 one cycle after s_rvalid.
- Write to slave 1: m_addr=0x1000_0004, m_sel=4'b0011, s_gnt[1] delayed 3 cycles -> s_req=2'b10 held 4 cycles, s_sel=0011, m_gnt on the 4th cycle, response m_err=0.
- Unmapped address 0x2000_0000 -> m_gnt=1 immediately, s_req=0, next cycle m_rvalid=1, m_err=1, m_rdata=0.
- Timeout: slave 0 grants but never sets rvalid, TIMEOUT_CYC=16 -> m_rvalid=1, m_err=1 exactly 17 cycles after the grant; a late s_rvalid[0] afterwards produces no m_rvalid.
- Overlapping windows (both masks 0, both bases 0) -> only s_req[0] asserted.
- rst_n asserted low while in WAIT -> m_rvalid=0, s_req=0 immediately; after release, a new read completes normally with m_err=0.
